// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
//  Shared definitions for the 2x2 convolution image path: default pixel width,
//  packed window width, byte-lane positions of the four window taps inside a
//  packed window, and the window generator FSM state encoding. The lane indices
//  are shared with the conv_core_2x2 wrappers so producer and consumer agree on
//  byte order.
//  Lane order (top row first): LANE_00=(0,0) in the most significant lane,
//  LANE_11=(1,1) in the least significant lane.
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_W = 4 * PIX_W;

    // Lane number n occupies bits [n*PIX_W +: PIX_W] of a packed window.
    localparam int LANE_00 = 3;
    localparam int LANE_01 = 2;
    localparam int LANE_10 = 1;
    localparam int LANE_11 = 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROW0   = 2'd1,
        S_STREAM = 2'd2
    } conv_state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_line_buffer
//  One image row of pixels (DEPTH x WIDTH). Asynchronous read, synchronous
//  write. When read and write address are equal in the same cycle the read
//  returns the old contents (read-before-write), which is how the window
//  generator fetches the pixel above while overwriting it with the current one.
//  Contents are not reset.
// Ports
//  clk      in   1      clock
//  i_we     in   1      write enable
//  i_waddr  in   AW     write address
//  i_wdata  in   WIDTH  write data
//  i_raddr  in   AW     read address
//  o_rdata  out  WIDTH  read data (combinational)
// -----------------------------------------------------------------------------
module conv_line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/conv_window_gen_2x2.sv
// -----------------------------------------------------------------------------
// conv_window_gen_2x2
//  Turns a raster pixel stream into packed 2x2 windows for conv_core_2x2.
//  Stride 1 by default; define CONV_WIN_STRIDE2_EN for non-overlapping 2x2
//  tiles (stride 2, IMG_W and IMG_H even).
//
//  Handshake: a transfer happens on a rising edge where valid & ready are both
//  high; valid never depends on ready, and once valid is high the payload is
//  held unchanged until the transfer. pix_ready = !win_valid | win_ready, so
//  the single output register can retire and reload in the same cycle.
//
// Ports
//  clk         in   1        clock
//  rst_n       in   1        asynchronous active-low reset
//  pix_valid   in   1        input pixel valid
//  pix_ready   out  1        input pixel ready (low during reset)
//  pix_data    in   PIX_W    pixel value, raster order
//  pix_sof     in   1        start of frame, marks pixel (0,0)
//  win_valid   out  1        window valid
//  win_ready   in   1        window accepted by consumer
//  win_data    out  4*PIX_W  {(0,0),(0,1),(1,0),(1,1)}, top row first
//  win_last    out  1        last window of the frame
//  frame_done  out  1        pulse the cycle after the last frame pixel is taken
//  sof_err     out  1        sticky: start of frame seen mid-frame
//  dbg_state   out  2        current FSM state
// -----------------------------------------------------------------------------
module conv_window_gen_2x2
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = conv_pkg::PIX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [PIX_W-1:0]     pix_data,
    input  logic                 pix_sof,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [4*PIX_W-1:0]   win_data,
    output logic                 win_last,
    output logic                 frame_done,
    output logic                 sof_err,
    output logic [1:0]           dbg_state
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Position of the final window of a frame.
`ifdef CONV_WIN_STRIDE2_EN
    localparam int LAST_C = ((IMG_W - 1) % 2 == 1) ? IMG_W - 1 : IMG_W - 2;
    localparam int LAST_R = ((IMG_H - 1) % 2 == 1) ? IMG_H - 1 : IMG_H - 2;
`else
    localparam int LAST_C = IMG_W - 1;
    localparam int LAST_R = IMG_H - 1;
`endif

    conv_state_e        r_state;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [PIX_W-1:0]   r_top_prev;
    logic [PIX_W-1:0]   r_bot_prev;
    logic               r_win_valid;
    logic [4*PIX_W-1:0] r_win_data;
    logic               r_win_last;
    logic               r_frame_done;
    logic               r_sof_err;

    logic               w_accept;
    logic               w_take;
    logic               w_restart;
    logic [CW-1:0]      w_col;
    logic [RW-1:0]      w_row;
    logic [PIX_W-1:0]   w_top;
    logic               w_col_end;
    logic               w_frame_end;
    logic               w_emit;
    logic               w_last;
    logic [4*PIX_W-1:0] w_win;

    assign pix_ready = rst_n & (!r_win_valid | win_ready);
    assign w_accept  = pix_valid & pix_ready;

    // In S_IDLE only a start-of-frame pixel is taken; everything else is dropped.
    assign w_take    = w_accept & (pix_sof | (r_state != S_IDLE));

    // A start-of-frame pixel always lands at (0,0), whatever the counters say.
    assign w_restart = pix_sof & (r_state != S_IDLE) &
                       ((r_col != '0) | (r_row != '0));
    assign w_col     = pix_sof ? '0 : r_col;
    assign w_row     = pix_sof ? '0 : r_row;

    assign w_col_end   = (w_col == CW'(IMG_W - 1));
    assign w_frame_end = w_col_end & (w_row == RW'(IMG_H - 1));

`ifdef CONV_WIN_STRIDE2_EN
    assign w_emit = w_take & w_row[0] & w_col[0];
`else
    assign w_emit = w_take & (w_row != '0) & (w_col != '0);
`endif
    assign w_last = w_emit & (w_col == CW'(LAST_C)) & (w_row == RW'(LAST_R));

    conv_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_take),
        .i_waddr (w_col),
        .i_wdata (pix_data),
        .i_raddr (w_col),
        .o_rdata (w_top)
    );

    always_comb begin
        w_win = '0;
        w_win[LANE_00*PIX_W +: PIX_W] = r_top_prev;
        w_win[LANE_01*PIX_W +: PIX_W] = w_top;
        w_win[LANE_10*PIX_W +: PIX_W] = r_bot_prev;
        w_win[LANE_11*PIX_W +: PIX_W] = pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_top_prev   <= '0;
            r_bot_prev   <= '0;
            r_win_valid  <= 1'b0;
            r_win_data   <= '0;
            r_win_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (r_win_valid && win_ready) begin
                r_win_valid <= 1'b0;
            end

            if (w_take) begin
                r_top_prev <= w_top;
                r_bot_prev <= pix_data;

                if (w_restart) begin
                    r_sof_err <= 1'b1;
                end

                // A new window overrides the retire above in the same cycle.
                if (w_emit) begin
                    r_win_valid <= 1'b1;
                    r_win_data  <= w_win;
                    r_win_last  <= w_last;
                end

                if (w_frame_end) begin
                    r_state      <= S_IDLE;
                    r_col        <= '0;
                    r_row        <= '0;
                    r_frame_done <= 1'b1;
                end else if (w_col_end) begin
                    r_state <= S_STREAM;
                    r_col   <= '0;
                    r_row   <= w_row + RW'(1);
                end else begin
                    r_state <= (w_row == '0) ? S_ROW0 : S_STREAM;
                    r_col   <= w_col + CW'(1);
                    r_row   <= w_row;
                end
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign win_data   = r_win_data;
    assign win_last   = r_win_last;
    assign frame_done = r_frame_done;
    assign sof_err    = r_sof_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_conv_window_gen_2x2.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen_2x2
//  Bench for conv_window_gen_2x2 with a small image. The reference model stores
//  each accepted pixel in a 2-D image array at the raster position given by
//  its index within the frame, and forms each expected window directly from
//  the four neighbouring image pixels.
// -----------------------------------------------------------------------------
module tb_conv_window_gen_2x2;

    localparam int IMG_W = 4;
`ifdef CONV_WIN_STRIDE2_EN
    localparam int IMG_H = 4;
`else
    localparam int IMG_H = 3;
`endif
    localparam int PIX_W = 8;
    localparam int WIN_W = 4 * PIX_W;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int W     = WIN_W + 1;   // {last, data}

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             rst_n;
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;
    logic             win_valid;
    logic             win_ready;
    logic [WIN_W-1:0] win_data;
    logic             win_last;
    logic             frame_done;
    logic             sof_err;
    logic [1:0]       dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    conv_window_gen_2x2 #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_last   (win_last),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .dbg_state  (dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     got_q[$];
    logic [PIX_W-1:0] img [IMG_H][IMG_W];
    bit               m_in_frame = 1'b0;
    int               m_idx      = 0;
    bit               m_err      = 1'b0;
    bit               m_fd       = 1'b0;
    bit               hold_chk   = 1'b0;
    logic [WIN_W-1:0] hold_data;
    logic             hold_last;
    logic [W-1:0]     pop_w;

`ifdef CONV_WIN_STRIDE2_EN
    localparam int LAST_R = ((IMG_H - 1) % 2 == 1) ? IMG_H - 1 : IMG_H - 2;
    localparam int LAST_C = ((IMG_W - 1) % 2 == 1) ? IMG_W - 1 : IMG_W - 2;
    function automatic bit emits(int r, int c);
        return (r % 2 == 1) && (c % 2 == 1);
    endfunction
`else
    localparam int LAST_R = IMG_H - 1;
    localparam int LAST_C = IMG_W - 1;
    function automatic bit emits(int r, int c);
        return (r >= 1) && (c >= 1);
    endfunction
`endif

    task automatic model_accept(input logic [PIX_W-1:0] d, input logic sof);
        int r;
        int c;
        if (sof) begin
            if (m_in_frame && m_idx != 0) m_err = 1'b1;
            m_idx      = 0;
            m_in_frame = 1'b1;
        end
        if (m_in_frame) begin
            r = m_idx / IMG_W;
            c = m_idx % IMG_W;
            img[r][c] = d;
            if (emits(r, c)) begin
                exp_q.push_back({(r == LAST_R && c == LAST_C),
                                 img[r-1][c-1], img[r-1][c], img[r][c-1], d});
            end
            m_idx++;
            if (m_idx == NPIX) begin
                m_in_frame = 1'b0;
                m_idx      = 0;
                m_fd       = 1'b1;
            end
        end
    endtask

    // ---------------- scoreboard / compare, every rising edge ----------------
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_in_frame = 1'b0;
                m_idx      = 0;
                m_err      = 1'b0;
                m_fd       = 1'b0;
                hold_chk   = 1'b0;
            end else begin
                chk("win_valid", win_valid, exp_q.size() != 0);
                chk("pix_ready", pix_ready, (exp_q.size() == 0) || win_ready);
                chk("frame_done", frame_done, m_fd);
                chk("sof_err", sof_err, m_err);
                if (hold_chk) begin
                    chk("hold_data", win_data, hold_data);
                    chk("hold_last", win_last, hold_last);
                end
                if (win_valid && win_ready && exp_q.size() != 0) begin
                    pop_w = exp_q.pop_front();
                    chk("window", {win_last, win_data}, pop_w);
                    got_q.push_back({win_last, win_data});
                end
                hold_chk  = win_valid && !win_ready;
                hold_data = win_data;
                hold_last = win_last;
                m_fd      = 1'b0;
                if (pix_valid && pix_ready) model_accept(pix_data, pix_sof);
            end
        end
    end

    // ---------------- consumer ready driver ----------------
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       win_ready = 1'b1;
                1:       win_ready = 1'($urandom_range(0, 1));
                default: win_ready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pix(input logic [PIX_W-1:0] d, input logic sof);
        bit done;
        done      = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (pix_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pix_timeout: pixel 0x%0h not accepted within 200 cycles", d);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int base, input int n, input bit sof_first, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_pix(PIX_W'(base + i), sof_first && (i == 0));
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) idle(1);
        chk("drain_empty", exp_q.size(), 0);
        idle(2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_sof   = 1'b0;
        idle(3);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_data", win_data, 0);
        chk("rst_win_last", win_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_ready", pix_ready, 1);

        // Basic frame 1..NPIX, consumer always ready.
        got_q.delete();
        send_frame(1, NPIX, 1'b1, 1'b0);
        chk("frame_done_lit", frame_done, 1);
        drain();
`ifdef CONV_WIN_STRIDE2_EN
        chk("s2_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("s2_win0", got_q[0], {1'b0, 32'h01020506});
            chk("s2_win1", got_q[1], {1'b0, 32'h03040708});
            chk("s2_win2", got_q[2], {1'b0, 32'h090A0D0E});
            chk("s2_win3", got_q[3], {1'b1, 32'h0B0C0F10});
        end
`else
        chk("t1_count", got_q.size(), 6);
        if (got_q.size() == 6) begin
            chk("t1_first", got_q[0], {1'b0, 32'h01020506});
            chk("t1_last", got_q[5], {1'b1, 32'h07080B0C});
        end
`endif

        // Same frame, consumer stalled for 5 cycles on the first window.
        got_q.delete();
        ready_mode = 2;
        fork
            send_frame(1, NPIX, 1'b1, 1'b0);
            begin
                for (int k = 0; k < 100 && !win_valid; k++) @(negedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk("t2_hold_lit", win_data, 32'h01020506);
                    chk("t2_ready_low", pix_ready, 0);
                end
                ready_mode = 0;
            end
        join
        drain();
        chk("t2_count", got_q.size(), (IMG_H - 1) * (IMG_W - 1) / ((IMG_H == 4) ? 9 : 1) * ((IMG_H == 4) ? 4 : 1));
        if (got_q.size() != 0) chk("t2_first", got_q[0], {1'b0, 32'h01020506});

        // Pixels without start of frame while idle are dropped.
        got_q.delete();
        send_frame(40, 5, 1'b0, 1'b0);
        idle(3);
        chk("t6_no_windows", got_q.size(), 0);
        chk("t6_sof_err", sof_err, 0);
        chk("t6_idle_state", dbg_state, 0);

        // Start of frame on pixel 7 restarts the frame and sets sof_err.
        got_q.delete();
        send_frame(1, 6, 1'b1, 1'b0);
        send_frame(7, NPIX, 1'b1, 1'b0);
        drain();
        chk("t3_sof_err", sof_err, 1);
        if (got_q.size() != 0) begin
`ifdef CONV_WIN_STRIDE2_EN
            chk("t3_last", got_q[got_q.size()-1], {1'b1, 32'h11121516});
`else
            chk("t3_last", got_q[got_q.size()-1], {1'b1, 32'h0D0E1112});
`endif
        end

        // Reset in the middle of row 2.
        send_frame(1, 2 * IMG_W + 2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_win_valid", win_valid, 0);
        chk("t4_win_data", win_data, 0);
        chk("t4_win_last", win_last, 0);
        chk("t4_frame_done", frame_done, 0);
        chk("t4_sof_err", sof_err, 0);
        chk("t4_pix_ready", pix_ready, 0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        got_q.delete();
        send_frame(100, NPIX, 1'b1, 1'b0);
        drain();
        chk("t4_after_count", got_q.size(), (IMG_H == 4) ? 4 : 6);

        // Randomized frames, random pixels, gaps and consumer back-pressure.
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                send_pix(PIX_W'($urandom), i == 0);
                idle($urandom_range(0, 2));
            end
        end
        ready_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
